// File: rtl/bp_me_lce_data_cmd_flit_serializer.sv
// ---------------------------------------------------------------------------
// bp_me_lce_data_cmd_flit_serializer
//
// Injection stage in front of the LCE data-command wormhole router. Takes one
// whole data-command payload plus destination coordinates, forms the wormhole
// packet {payload, len, y_cord, x_cord} (header in the LSBs), zero-pads it to
// a whole number of flits and streams it out one flit per handshake.
// One packet is buffered. A new packet may be accepted in the same cycle as
// the last flit of the current one, so back-to-back packets leave no bubble.
//
// Ports
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   payload_i  : data-command payload          (payload_width_p)
//   dst_x_i    : destination X coordinate      (x_cord_width_p)
//   dst_y_i    : destination Y coordinate      (y_cord_width_p)
//   v_i        : packet valid
//   ready_o    : packet accept (combinational from ready_i on the last flit)
//   flit_o     : current flit                  (flit_width_p)
//   v_o        : flit valid
//   ready_i    : router input port ready
//   busy_o     : a packet is held and being sent
// ---------------------------------------------------------------------------
module bp_me_lce_data_cmd_flit_serializer #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int payload_width_p = 100,
  parameter int flit_width_p    = 32,
  parameter int max_num_flit_p  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [payload_width_p-1:0] payload_i,
  input  logic [x_cord_width_p-1:0]  dst_x_i,
  input  logic [y_cord_width_p-1:0]  dst_y_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [flit_width_p-1:0]    flit_o,
  output logic                       v_o,
  input  logic                       ready_i,
  output logic                       busy_o
);

  localparam int len_width_lp    = (max_num_flit_p > 1) ? $clog2(max_num_flit_p) : 1;
  localparam int packet_width_lp = x_cord_width_p + y_cord_width_p + len_width_lp
                                   + payload_width_p;
  localparam int num_flit_lp     = (packet_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int padded_width_lp = num_flit_lp * flit_width_p;
  localparam int cnt_width_lp    = (num_flit_lp > 1) ? $clog2(num_flit_lp) : 1;

  localparam logic [len_width_lp-1:0] len_val_lp = len_width_lp'(num_flit_lp - 1);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(num_flit_lp - 1);

  if (num_flit_lp > max_num_flit_p) begin : g_cfg_err
    $error("packet needs more flits than max_num_flit_p allows");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic [padded_width_lp-1:0] pkt_q, pkt_d;
  // Holds ready_o low through reset and until the first clock edge after it.
  logic                       init_q, init_d;

  logic [packet_width_lp-1:0] packet_new;
  logic [padded_width_lp-1:0] padded_new;
  logic                       last_flit;
  logic                       flit_hs;
  logic                       last_hs;
  logic                       accept;

  // Packet assembly: header in the LSBs, zero padding above the payload.
  always_comb begin
    packet_new = {payload_i, len_val_lp, dst_y_i, dst_x_i};
    padded_new = '0;
    padded_new[packet_width_lp-1:0] = packet_new;
  end

  assign v_o       = (state_q == SEND);
  assign busy_o    = (state_q == SEND);
  assign last_flit = (cnt_q == cnt_last_lp);
  assign flit_hs   = v_o & ready_i;
  assign last_hs   = flit_hs & last_flit;

  // The only input-to-output combinational path: ready_i -> ready_o, so a
  // new packet can replace the current one as its last flit leaves.
  assign ready_o = init_q & ((state_q == IDLE) | last_hs);
  assign accept  = v_i & ready_o;

  // Flit select from the registered packet and counter only.
  always_comb begin
    flit_o = '0;
    for (int k = 0; k < num_flit_lp; k++) begin
      if (cnt_q == cnt_width_lp'(k)) begin
        flit_o = pkt_q[k*flit_width_p +: flit_width_p];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    init_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pkt_d   = padded_new;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (flit_hs) begin
          if (!last_flit) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (accept) begin
              pkt_d = padded_new;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single register stage: packet buffer, flit counter, FSM state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      init_q  <= init_d;
    end
  end

endmodule

// File: tb/tb_bp_me_lce_data_cmd_flit_serializer.sv
module tb_bp_me_lce_data_cmd_flit_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  // DUT A: default configuration, 4 flits of 32 bits
  logic [99:0]  a_payload;
  logic [3:0]   a_x, a_y;
  logic         a_v, a_ready_o, a_v_o, a_rdy, a_busy;
  logic [31:0]  a_flit;

  // DUT B: 128-bit flits, one flit per packet
  logic [99:0]  b_payload;
  logic [3:0]   b_x, b_y;
  logic         b_v, b_ready_o, b_v_o, b_rdy, b_busy;
  logic [127:0] b_flit;

  bp_me_lce_data_cmd_flit_serializer u_dut_a (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .payload_i (a_payload),
    .dst_x_i   (a_x),
    .dst_y_i   (a_y),
    .v_i       (a_v),
    .ready_o   (a_ready_o),
    .flit_o    (a_flit),
    .v_o       (a_v_o),
    .ready_i   (a_rdy),
    .busy_o    (a_busy)
  );

  bp_me_lce_data_cmd_flit_serializer #(.flit_width_p(128)) u_dut_b (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .payload_i (b_payload),
    .dst_x_i   (b_x),
    .dst_y_i   (b_y),
    .v_i       (b_v),
    .ready_o   (b_ready_o),
    .flit_o    (b_flit),
    .v_o       (b_v_o),
    .ready_i   (b_rdy),
    .busy_o    (b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int a_xfer = 0;
  int b_xfer = 0;

  logic [31:0]  qa[$];
  logic [127:0] qb[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference packet: x in [3:0], y in [7:4], len in [9:8], payload in [109:10].
  function automatic logic [127:0] model_pkt(input logic [99:0] pl, input logic [3:0] x,
                                             input logic [3:0] y, input logic [1:0] len);
    logic [127:0] r;
    r          = '0;
    r[3:0]     = x;
    r[7:4]     = y;
    r[9:8]     = len;
    r[109:10]  = pl;
    return r;
  endfunction

  // Output monitor: every flit handshake pops and checks the scoreboard.
  always @(negedge clk) begin
    logic [31:0]  ea;
    logic [127:0] eb;
    if (a_v_o && a_rdy) begin
      a_xfer++;
      if (qa.size() == 0) chk("a_unexpected_flit", {96'd0, a_flit}, 128'hx);
      else begin
        ea = qa.pop_front();
        chk("a_flit", {96'd0, a_flit}, {96'd0, ea});
      end
    end
    if (b_v_o && b_rdy) begin
      b_xfer++;
      if (qb.size() == 0) chk("b_unexpected_flit", b_flit, 128'hx);
      else begin
        eb = qb.pop_front();
        chk("b_flit", b_flit, eb);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a packet to DUT A, wait (bounded) for accept, queue its flits.
  // Leaves v_i asserted; returns at accept edge + 1.
  task automatic send_a(input logic [99:0] pl, input logic [3:0] x, input logic [3:0] y,
                        output int waits);
    logic [127:0] p;
    a_payload = pl;
    a_x = x;
    a_y = y;
    a_v = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (a_ready_o) break;
      waits++;
      if (waits > 50) begin
        chk("a_accept_timeout", 0, 1);
        return;
      end
    end
    p = model_pkt(pl, x, y, 2'd3);
    for (int k = 0; k < 4; k++) qa.push_back(p[k*32 +: 32]);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic [99:0]  pl;
    logic [127:0] rr;
    logic [127:0] p;

    a_payload = '0; a_x = '0; a_y = '0; a_v = 0; a_rdy = 1;
    b_payload = '0; b_x = '0; b_y = '0; b_v = 0; b_rdy = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a_v_o", a_v_o, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_flit", a_flit, 0);
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_b_v_o", b_v_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_a_ready_before_edge", a_ready_o, 0);
    tick();
    chk("rel_a_ready_after_edge", a_ready_o, 1);
    chk("rel_b_ready_after_edge", b_ready_o, 1);

    // Single packet, continuous ready
    base = a_xfer;
    send_a(100'hDEAD_BEEF, 4'h3, 4'h5, w);
    a_v = 1'b0;
    chk("single_v_o_next_cycle", a_v_o, 1);
    chk("single_flit0_const", a_flit, 32'hB6FB_BF53);
    tick();
    chk("single_flit1_const", a_flit, 32'h0000_037A);
    repeat (3) tick();
    chk("single_idle_v_o", a_v_o, 0);
    chk("single_idle_busy", a_busy, 0);
    chk("single_flit_count", a_xfer - base, 4);

    // Backpressure on flit 2
    base = a_xfer;
    pl = 100'h1_2345_6789_ABCD_EF01_2345_6789;
    p = model_pkt(pl, 4'hA, 4'h6, 2'd3);
    send_a(pl, 4'hA, 4'h6, w);
    a_v = 1'b0;
    tick();
    tick();
    a_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_v_o", a_v_o, 1);
      chk("stall_flit2", a_flit, p[95:64]);
      tick();
    end
    a_rdy = 1'b1;
    tick();
    tick();
    chk("stall_idle_v_o", a_v_o, 0);
    chk("stall_flit_count", a_xfer - base, 4);

    // Back-to-back with inputs ignored while busy
    base = a_xfer;
    send_a(100'hA_AAAA_5555_0000_FFFF_1234_4321, 4'h1, 4'h2, w);
    for (int i = 0; i < 3; i++) begin
      rr = {$urandom(), $urandom(), $urandom(), $urandom()};
      a_payload = rr[99:0];
      a_x = rr[103:100];
      a_y = rr[107:104];
      @(negedge clk);
      chk("busy_ready_low", a_ready_o, 0);
      tick();
    end
    send_a(100'hB_0B0B_0B0B_0B0B_0B0B_0B0B_0B0B, 4'hF, 4'hE, w);
    a_v = 1'b0;
    chk("b2b_wait_cycles", w, 0);
    repeat (3) tick();
    chk("b2b_v_o_last", a_v_o, 1);
    tick();
    chk("b2b_idle_v_o", a_v_o, 0);
    chk("b2b_flit_count", a_xfer - base, 8);

    // Asynchronous reset mid-packet
    send_a(100'hC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC, 4'h7, 4'h8, w);
    a_v = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    qa.delete();
    #1;
    chk("arst_v_o", a_v_o, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_ready", a_ready_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
    base = a_xfer;
    send_a(100'hD_1111_2222_3333_4444_5555_6666, 4'h9, 4'h4, w);
    a_v = 1'b0;
    chk("post_rst_len", a_flit[9:8], 2'd3);
    chk("post_rst_hdr", a_flit[7:0], 8'h49);
    repeat (4) tick();
    chk("post_rst_idle", a_v_o, 0);
    chk("post_rst_flit_count", a_xfer - base, 4);

    // 128-bit flit variant: one flit per packet, continuous accept
    base = b_xfer;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        b_payload = 100'hDEAD_BEEF;
        b_x = 4'h3;
        b_y = 4'h5;
      end else begin
        rr = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_payload = rr[99:0];
        b_x = rr[103:100];
        b_y = rr[107:104];
      end
      b_v = 1'b1;
      @(negedge clk);
      chk("b_ready_cont", b_ready_o, 1);
      qb.push_back(model_pkt(b_payload, b_x, b_y, 2'd0));
      if (i == 1) chk("b_flit_const", b_flit, 128'h37A_B6FB_BC53);
      tick();
    end
    b_v = 1'b0;
    tick();
    chk("b_idle_v_o", b_v_o, 0);
    chk("b_flit_count", b_xfer - base, 6);

    tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
